enigma_arbiter: RTL and testbench

ENIGMA_ARBITER -- requirements
Module: enigma_arbiter

---
 rtl/enigma_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_enigma_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enigma_arbiter.sv
// Two-requester arbiter with an ID-indexed outstanding scoreboard, starvation/QoS/round-robin
// grant priority, and a single registered output slot that can stall on downstream conflict.
module enigma_arbiter #(
    parameter int PAYLOAD_W    = 128,
    parameter int STARVE_LIMIT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PAYLOAD_W-1:0] payload_a,
    input  logic [4:0]           id_a,
    input  logic [1:0]           qos_a,
    input  logic                 valid_a,
    output logic                 ready_a,
    input  logic [PAYLOAD_W-1:0] payload_b,
    input  logic [4:0]           id_b,
    input  logic [1:0]           qos_b,
    input  logic                 valid_b,
    output logic                 ready_b,
    output logic                 valid_c,
    output logic [PAYLOAD_W-1:0] payload_c,
    output logic [5:0]           id_c,
    output logic [1:0]           qos_c,
    input  logic                 ready_c,
    input  logic                 conflict_c,
    input  logic                 release_c,
    input  logic [5:0]           releaseid_c,
    output logic [6:0]           outst_cnt,
    output logic                 err_release
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    function automatic logic [6:0] popcount64(input logic [63:0] v);
        logic [6:0] cnt;
        cnt = 7'd0;
        for (int i = 0; i < 64; i++) begin
            cnt = cnt + 7'(v[i]);
        end
        return cnt;
    endfunction

    state_t                 state_r;
    logic                   valid_c_r;
    logic [PAYLOAD_W-1:0]   payload_c_r;
    logic [5:0]             id_c_r;
    logic [1:0]             qos_c_r;
    logic [63:0]            sb_r;
    logic [6:0]             outst_cnt_r;
    logic                   err_release_r;
    logic [7:0]             wait_a_r;
    logic [7:0]             wait_b_r;
    logic                   prefer_a_r;

    logic                   elig_a_s;
    logic                   elig_b_s;
    logic                   starve_a_s;
    logic                   starve_b_s;
    logic                   complete_s;
    logic                   reject_s;
    logic                   slot_free_s;
    logic                   gnt_a_s;
    logic                   gnt_b_s;
    logic                   grant_s;
    logic [5:0]             grant_id_s;
    logic [63:0]            clr_mask_s;
    logic [63:0]            set_mask_s;
    logic [63:0]            sb_next_s;
    logic                   err_set_s;

    // Eligibility looks at the scoreboard as registered, before this cycle's release/grant.
    assign elig_a_s    = valid_a & ~sb_r[{1'b0, id_a}];
    assign elig_b_s    = valid_b & ~sb_r[{1'b1, id_b}];
    assign starve_a_s  = (wait_a_r == LIMIT);
    assign starve_b_s  = (wait_b_r == LIMIT);

    assign complete_s  = (state_r == ST_SEND) & ready_c & ~conflict_c;
    assign reject_s    = (state_r == ST_SEND) & ready_c & conflict_c;
    assign slot_free_s = (state_r == ST_IDLE) | complete_s;

    // Grant selection: starvation, then QoS, then round-robin; both-starved falls to round-robin.
    always_comb begin
        gnt_a_s = 1'b0;
        gnt_b_s = 1'b0;
        if (rst || !slot_free_s) begin
            gnt_a_s = 1'b0;
            gnt_b_s = 1'b0;
        end else if (elig_a_s && elig_b_s) begin
            if (starve_a_s != starve_b_s) begin
                gnt_b_s = starve_b_s;
            end else if (!starve_a_s && (qos_a != qos_b)) begin
                gnt_b_s = (qos_b > qos_a);
            end else begin
                gnt_b_s = ~prefer_a_r;
            end
            gnt_a_s = ~gnt_b_s;
        end else if (elig_a_s) begin
            gnt_a_s = 1'b1;
        end else if (elig_b_s) begin
            gnt_b_s = 1'b1;
        end else begin
            gnt_a_s = 1'b0;
            gnt_b_s = 1'b0;
        end
    end

    assign grant_s    = gnt_a_s | gnt_b_s;
    assign grant_id_s = gnt_b_s ? {1'b1, id_b} : {1'b0, id_a};

    // A release can never hit the ID being granted, so clear and set masks are disjoint.
    assign clr_mask_s = (release_c & sb_r[releaseid_c]) ? (64'd1 << releaseid_c) : 64'd0;
    assign set_mask_s = grant_s ? (64'd1 << grant_id_s) : 64'd0;
    assign sb_next_s  = (sb_r & ~clr_mask_s) | set_mask_s;
    assign err_set_s  = release_c & ~sb_r[releaseid_c];

    // Scoreboard, counters, starvation tracking and the output-slot state machine.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            valid_c_r     <= 1'b0;
            payload_c_r   <= {PAYLOAD_W{1'b0}};
            id_c_r        <= 6'd0;
            qos_c_r       <= 2'd0;
            sb_r          <= 64'd0;
            outst_cnt_r   <= 7'd0;
            err_release_r <= 1'b0;
            wait_a_r      <= 8'd0;
            wait_b_r      <= 8'd0;
            prefer_a_r    <= 1'b1;
        end else begin
            sb_r        <= sb_next_s;
            outst_cnt_r <= popcount64(sb_next_s);

            if (err_set_s) begin
                err_release_r <= 1'b1;
            end

            if (gnt_a_s || !elig_a_s) begin
                wait_a_r <= 8'd0;
            end else if (wait_a_r < LIMIT) begin
                wait_a_r <= wait_a_r + 8'd1;
            end

            if (gnt_b_s || !elig_b_s) begin
                wait_b_r <= 8'd0;
            end else if (wait_b_r < LIMIT) begin
                wait_b_r <= wait_b_r + 8'd1;
            end

            if (grant_s) begin
                prefer_a_r  <= gnt_b_s;
                payload_c_r <= gnt_b_s ? payload_b : payload_a;
                qos_c_r     <= gnt_b_s ? qos_b : qos_a;
                id_c_r      <= grant_id_s;
            end

            case (state_r)
                ST_IDLE: begin
                    if (grant_s) begin
                        state_r   <= ST_SEND;
                        valid_c_r <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (complete_s && grant_s) begin
                        state_r   <= ST_SEND;
                        valid_c_r <= 1'b1;
                    end else if (complete_s) begin
                        state_r   <= ST_IDLE;
                        valid_c_r <= 1'b0;
                    end else if (reject_s) begin
                        state_r   <= ST_STALL;
                        valid_c_r <= 1'b0;
                    end
                end
                ST_STALL: begin
                    // Any release wakes the stalled beat; the held request is re-presented as-is.
                    if (release_c) begin
                        state_r   <= ST_SEND;
                        valid_c_r <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    valid_c_r <= 1'b0;
                end
            endcase
        end
    end

    assign ready_a     = gnt_a_s;
    assign ready_b     = gnt_b_s;
    assign valid_c     = valid_c_r;
    assign payload_c   = payload_c_r;
    assign id_c        = id_c_r;
    assign qos_c       = qos_c_r;
    assign outst_cnt   = outst_cnt_r;
    assign err_release = err_release_r;

endmodule

// File: tb/tb_enigma_arbiter.sv
// Self-checking bench for enigma_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of the arbiter.
module tb_enigma_arbiter;

    localparam int PW  = 128;
    localparam int LIM = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic [PW-1:0] payload_a, payload_b, payload_c;
    logic [4:0]    id_a, id_b;
    logic [1:0]    qos_a, qos_b, qos_c;
    logic          valid_a, valid_b, ready_a, ready_b;
    logic          valid_c, ready_c, conflict_c, release_c;
    logic [5:0]    id_c, releaseid_c;
    logic [6:0]    outst_cnt;
    logic          err_release;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    logic [63:0]   m_out;
    logic          m_busy, m_stalled, m_prefer_a, m_err;
    logic [PW-1:0] m_pay;
    logic [5:0]    m_id;
    logic [1:0]    m_qos;
    int            m_wait_a, m_wait_b;
    logic          exp_ready_a, exp_ready_b;

    always #5 clk = ~clk;

    enigma_arbiter #(.PAYLOAD_W(PW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst),
        .payload_a(payload_a), .id_a(id_a), .qos_a(qos_a), .valid_a(valid_a), .ready_a(ready_a),
        .payload_b(payload_b), .id_b(id_b), .qos_b(qos_b), .valid_b(valid_b), .ready_b(ready_b),
        .valid_c(valid_c), .payload_c(payload_c), .id_c(id_c), .qos_c(qos_c),
        .ready_c(ready_c), .conflict_c(conflict_c), .release_c(release_c),
        .releaseid_c(releaseid_c), .outst_cnt(outst_cnt), .err_release(err_release)
    );

    task automatic model_predict();
        logic ea, eb, free, win_b, sa, sb;
        exp_ready_a = 1'b0;
        exp_ready_b = 1'b0;
        ea   = valid_a && !m_out[{1'b0, id_a}];
        eb   = valid_b && !m_out[{1'b1, id_b}];
        free = !m_busy || (!m_stalled && ready_c && !conflict_c);
        if (!rst && free) begin
            if (ea && eb) begin
                sa = (m_wait_a >= LIM);
                sb = (m_wait_b >= LIM);
                if (sa != sb) win_b = sb;
                else if (!sa && qos_a != qos_b) win_b = (qos_b > qos_a);
                else win_b = !m_prefer_a;
                exp_ready_a = !win_b;
                exp_ready_b = win_b;
            end else begin
                exp_ready_a = ea;
                exp_ready_b = eb;
            end
        end
    endtask

    task automatic model_commit();
        logic ea, eb, done, rej;
        logic [63:0] nxt;
        if (rst) begin
            m_out = 64'd0; m_busy = 1'b0; m_stalled = 1'b0; m_prefer_a = 1'b1; m_err = 1'b0;
            m_pay = '0; m_id = 6'd0; m_qos = 2'd0; m_wait_a = 0; m_wait_b = 0;
        end else begin
            ea   = valid_a && !m_out[{1'b0, id_a}];
            eb   = valid_b && !m_out[{1'b1, id_b}];
            done = m_busy && !m_stalled && ready_c && !conflict_c;
            rej  = m_busy && !m_stalled && ready_c && conflict_c;
            nxt  = m_out;
            if (release_c) begin
                if (m_out[releaseid_c]) nxt[releaseid_c] = 1'b0;
                else m_err = 1'b1;
            end
            if (exp_ready_a) begin
                nxt[{1'b0, id_a}] = 1'b1;
                m_pay = payload_a; m_id = {1'b0, id_a}; m_qos = qos_a;
                m_busy = 1'b1; m_stalled = 1'b0; m_prefer_a = 1'b0;
            end else if (exp_ready_b) begin
                nxt[{1'b1, id_b}] = 1'b1;
                m_pay = payload_b; m_id = {1'b1, id_b}; m_qos = qos_b;
                m_busy = 1'b1; m_stalled = 1'b0; m_prefer_a = 1'b1;
            end else if (done) begin
                m_busy = 1'b0;
            end else if (rej) begin
                m_stalled = 1'b1;
            end else if (m_stalled && release_c) begin
                m_stalled = 1'b0;
            end
            m_wait_a = (exp_ready_a || !ea) ? 0 : ((m_wait_a < LIM) ? m_wait_a + 1 : LIM);
            m_wait_b = (exp_ready_b || !eb) ? 0 : ((m_wait_b < LIM) ? m_wait_b + 1 : LIM);
            m_out = nxt;
        end
    endtask

    task automatic tick();
        model_predict();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        payload_a = '0; id_a = 5'd0; qos_a = 2'd0; valid_a = 1'b0;
        payload_b = '0; id_b = 5'd0; qos_b = 2'd0; valid_b = 1'b0;
        ready_c = 1'b0; conflict_c = 1'b0; release_c = 1'b0; releaseid_c = 6'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        valid_a = 1'b1; id_a = 5'd1; valid_b = 1'b1; id_b = 5'd2;
        #1;
        checks++; if (ready_a !== 1'b0 || ready_b !== 1'b0) begin failures++;
            $display("FAIL reset_ready: got a=%0b b=%0b expected 0 0", ready_a, ready_b); end
        tick();
        tick();
        rst = 1'b0;
        idle_inputs();
        #1;
        checks++; if (valid_c !== 1'b0) begin failures++;
            $display("FAIL reset_valid_c: got %0b expected 0", valid_c); end
        checks++; if (payload_c !== '0 || id_c !== 6'd0 || qos_c !== 2'd0) begin failures++;
            $display("FAIL reset_outregs: got id=%0h qos=%0d payload=%0h expected zeros", id_c, qos_c, payload_c); end
        checks++; if (outst_cnt !== 7'd0 || err_release !== 1'b0) begin failures++;
            $display("FAIL reset_cnt_err: got cnt=%0d err=%0b expected 0 0", outst_cnt, err_release); end
    endtask

    task automatic test_single();
        logic [PW-1:0] p;
        do_reset();
        p = {$urandom, $urandom, $urandom, $urandom};
        valid_a = 1'b1; id_a = 5'd3; qos_a = 2'd0; payload_a = p; ready_c = 1'b1;
        #1;
        checks++; if (ready_a !== 1'b1 || ready_b !== 1'b0) begin failures++;
            $display("FAIL single_grant: got a=%0b b=%0b expected 1 0", ready_a, ready_b); end
        tick();
        valid_a = 1'b0;
        #1;
        checks++; if (valid_c !== 1'b1 || id_c !== 6'h03) begin failures++;
            $display("FAIL single_out: got valid=%0b id=%0h expected 1 03", valid_c, id_c); end
        checks++; if (payload_c !== p || outst_cnt !== 7'd1) begin failures++;
            $display("FAIL single_payload_cnt: got cnt=%0d payload=%0h expected 1 %0h", outst_cnt, payload_c, p); end
        tick();
        checks++; if (valid_c !== 1'b0) begin failures++;
            $display("FAIL single_idle: got valid=%0b expected 0", valid_c); end
    endtask

    task automatic test_qos();
        do_reset();
        valid_a = 1'b1; id_a = 5'd5; qos_a = 2'd1;
        valid_b = 1'b1; id_b = 5'd5; qos_b = 2'd3; ready_c = 1'b1;
        #1;
        checks++; if (ready_a !== 1'b0 || ready_b !== 1'b1) begin failures++;
            $display("FAIL qos_grant: got a=%0b b=%0b expected 0 1", ready_a, ready_b); end
        tick();
        valid_b = 1'b0;
        #1;
        checks++; if (valid_c !== 1'b1 || id_c !== 6'h25 || qos_c !== 2'd3) begin failures++;
            $display("FAIL qos_out_b: got valid=%0b id=%0h qos=%0d expected 1 25 3", valid_c, id_c, qos_c); end
        checks++; if (ready_a !== 1'b1) begin failures++;
            $display("FAIL qos_backtoback_a: got %0b expected 1", ready_a); end
        tick();
        valid_a = 1'b0;
        #1;
        checks++; if (valid_c !== 1'b1 || id_c !== 6'h05 || outst_cnt !== 7'd2) begin failures++;
            $display("FAIL qos_out_a: got valid=%0b id=%0h cnt=%0d expected 1 05 2", valid_c, id_c, outst_cnt); end
    endtask

    task automatic test_starve();
        logic [4:0] a_id;
        logic seen_b;
        int got;
        do_reset();
        a_id = 5'd0; seen_b = 1'b0; got = -1;
        valid_a = 1'b1; qos_a = 2'd3; valid_b = 1'b1; id_b = 5'd1; qos_b = 2'd0; ready_c = 1'b1;
        for (int c = 0; c < 40 && !seen_b; c++) begin
            id_a = a_id;
            #1;
            checks++; if (ready_a === 1'b1 && ready_b === 1'b1) begin failures++;
                $display("FAIL starve_exclusive: cycle %0d got both ready expected one", c); end
            if (ready_b === 1'b1) begin
                seen_b = 1'b1;
                got = c;
            end else if (ready_a === 1'b1) begin
                a_id = a_id + 5'd1;
            end
            tick();
        end
        checks++; if (!seen_b || got < 1 || got > LIM + 1) begin failures++;
            $display("FAIL starve_latency: got grant cycle %0d expected 1..%0d", got, LIM + 1); end
        idle_inputs();
    endtask

    task automatic test_conflict();
        logic [PW-1:0] p;
        do_reset();
        p = {$urandom, $urandom, $urandom, $urandom};
        valid_a = 1'b1; id_a = 5'd7; payload_a = p;
        #1;
        tick();
        valid_a = 1'b0; ready_c = 1'b1; conflict_c = 1'b1;
        #1;
        checks++; if (valid_c !== 1'b1 || id_c !== 6'h07) begin failures++;
            $display("FAIL conflict_beat: got valid=%0b id=%0h expected 1 07", valid_c, id_c); end
        tick();
        ready_c = 1'b0; conflict_c = 1'b0; release_c = 1'b1; releaseid_c = 6'h01;
        valid_b = 1'b1; id_b = 5'd9;
        #1;
        checks++; if (valid_c !== 1'b0 || ready_b !== 1'b0) begin failures++;
            $display("FAIL conflict_stall: got valid=%0b ready_b=%0b expected 0 0", valid_c, ready_b); end
        tick();
        release_c = 1'b0; valid_b = 1'b0;
        #1;
        checks++; if (valid_c !== 1'b1 || id_c !== 6'h07 || payload_c !== p) begin failures++;
            $display("FAIL conflict_replay: got valid=%0b id=%0h payload=%0h expected 1 07 %0h", valid_c, id_c, payload_c, p); end
        checks++; if (err_release !== 1'b1 || outst_cnt !== 7'd1) begin failures++;
            $display("FAIL conflict_err_cnt: got err=%0b cnt=%0d expected 1 1", err_release, outst_cnt); end
    endtask

    task automatic test_reuse();
        do_reset();
        valid_a = 1'b1; id_a = 5'd2; ready_c = 1'b1;
        #1;
        checks++; if (ready_a !== 1'b1) begin failures++;
            $display("FAIL reuse_first: got %0b expected 1", ready_a); end
        tick();
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++; if (ready_a !== 1'b0 || outst_cnt !== 7'd1) begin failures++;
                $display("FAIL reuse_blocked: cycle %0d got ready=%0b cnt=%0d expected 0 1", c, ready_a, outst_cnt); end
            tick();
        end
        release_c = 1'b1; releaseid_c = 6'h02;
        #1;
        checks++; if (ready_a !== 1'b0) begin failures++;
            $display("FAIL reuse_release_cycle: got %0b expected 0", ready_a); end
        tick();
        release_c = 1'b0;
        #1;
        checks++; if (ready_a !== 1'b1 || outst_cnt !== 7'd0) begin failures++;
            $display("FAIL reuse_regrant: got ready=%0b cnt=%0d expected 1 0", ready_a, outst_cnt); end
        tick();
        valid_a = 1'b0;
        #1;
        checks++; if (outst_cnt !== 7'd1 || valid_c !== 1'b1 || id_c !== 6'h02 || err_release !== 1'b0) begin failures++;
            $display("FAIL reuse_final: got cnt=%0d valid=%0b id=%0h err=%0b expected 1 1 02 0", outst_cnt, valid_c, id_c, err_release); end
    endtask

    task automatic test_err_reset();
        do_reset();
        release_c = 1'b1; releaseid_c = 6'h3F;
        tick();
        release_c = 1'b0;
        #1;
        checks++; if (err_release !== 1'b1 || outst_cnt !== 7'd0) begin failures++;
            $display("FAIL err_set: got err=%0b cnt=%0d expected 1 0", err_release, outst_cnt); end
        tick();
        tick();
        checks++; if (err_release !== 1'b1) begin failures++;
            $display("FAIL err_sticky: got %0b expected 1", err_release); end
        valid_a = 1'b1; id_a = 5'd4; qos_a = 2'd2; payload_a = {4{$urandom}};
        tick();
        valid_a = 1'b0;
        #1;
        checks++; if (valid_c !== 1'b1 || id_c !== 6'h04) begin failures++;
            $display("FAIL err_send: got valid=%0b id=%0h expected 1 04", valid_c, id_c); end
        rst = 1'b1; valid_a = 1'b1; id_a = 5'd6;
        #1;
        checks++; if (ready_a !== 1'b0) begin failures++;
            $display("FAIL midreset_ready: got %0b expected 0", ready_a); end
        tick();
        rst = 1'b0; valid_a = 1'b0;
        #1;
        checks++; if (valid_c !== 1'b0 || payload_c !== '0 || id_c !== 6'd0 || qos_c !== 2'd0) begin failures++;
            $display("FAIL midreset_out: got valid=%0b id=%0h qos=%0d expected 0 0 0", valid_c, id_c, qos_c); end
        checks++; if (outst_cnt !== 7'd0 || err_release !== 1'b0) begin failures++;
            $display("FAIL midreset_cnt_err: got cnt=%0d err=%0b expected 0 0", outst_cnt, err_release); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst         = ($urandom_range(0, 299) == 0);
            valid_a     = ($urandom_range(0, 9) < 6);
            valid_b     = ($urandom_range(0, 9) < 6);
            id_a        = 5'($urandom_range(0, 7));
            id_b        = 5'($urandom_range(0, 7));
            qos_a       = 2'($urandom_range(0, 3));
            qos_b       = 2'($urandom_range(0, 3));
            payload_a   = {$urandom, $urandom, $urandom, $urandom};
            payload_b   = {$urandom, $urandom, $urandom, $urandom};
            ready_c     = ($urandom_range(0, 9) < 7);
            conflict_c  = ($urandom_range(0, 9) < 2);
            release_c   = ($urandom_range(0, 9) < 3);
            releaseid_c = {1'($urandom_range(0, 1)), 5'($urandom_range(0, 7))};
            #1;
            model_predict();
            checks++; if (ready_a !== exp_ready_a || ready_b !== exp_ready_b) begin failures++;
                $display("FAIL rand_ready: cycle %0d got a=%0b b=%0b expected %0b %0b", c, ready_a, ready_b, exp_ready_a, exp_ready_b); end
            checks++; if (valid_c !== (m_busy && !m_stalled)) begin failures++;
                $display("FAIL rand_valid_c: cycle %0d got %0b expected %0b", c, valid_c, m_busy && !m_stalled); end
            if (m_busy && !m_stalled) begin
                checks++; if (id_c !== m_id || qos_c !== m_qos || payload_c !== m_pay) begin failures++;
                    $display("FAIL rand_req: cycle %0d got id=%0h qos=%0d expected %0h %0d", c, id_c, qos_c, m_id, m_qos); end
            end
            checks++; if (outst_cnt !== 7'($countones(m_out))) begin failures++;
                $display("FAIL rand_outst: cycle %0d got %0d expected %0d", c, outst_cnt, $countones(m_out)); end
            checks++; if (err_release !== m_err) begin failures++;
                $display("FAIL rand_err: cycle %0d got %0b expected %0b", c, err_release, m_err); end
            tick();
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        m_out = 64'd0; m_busy = 1'b0; m_stalled = 1'b0; m_prefer_a = 1'b1; m_err = 1'b0;
        m_pay = '0; m_id = 6'd0; m_qos = 2'd0; m_wait_a = 0; m_wait_b = 0;
        exp_ready_a = 1'b0; exp_ready_b = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_qos();
        test_starve();
        test_conflict();
        test_reuse();
        test_err_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
